// File: rtl/jt49_cmdseq_if.sv
`default_nettype none
// ============================================================================
// Module   : jt49_cmdseq_if
// Purpose  : Bundles the jt49_cmdseq host controls, command-memory read port
//            and jt49 write bus into one interface.
//            master = sequencer side, slave = host/memory/PSG side.
// Revision : 1.0 - initial release
// ============================================================================
interface jt49_cmdseq_if #(
    parameter int AW = 7
);
    logic          cen;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] cmd_addr;
    logic [11:0]   cmd_data;
    logic [3:0]    psg_addr;
    logic [7:0]    psg_din;
    logic          psg_wr_n;

    modport master (
        input  cen, start, abort, cmd_data,
        output busy, done, cmd_addr, psg_addr, psg_din, psg_wr_n
    );

    modport slave (
        output cen, start, abort, cmd_data,
        input  busy, done, cmd_addr, psg_addr, psg_din, psg_wr_n
    );
endinterface
`default_nettype wire

// File: rtl/jt49_cmdseq.sv
`default_nettype none
// ============================================================================
// Module   : jt49_cmdseq
// Purpose  : Command-list player for the jt49 PSG. It fetches 12-bit
//            {op,data} words from a synchronous command memory. It issues
//            one-clock register writes (op 0..D), cen-timed waits (op F) and
//            end-of-list (op E).
// Options  : JT49_CMDSEQ_LOOP_EN - op E with data[7]=1 jumps to data[6:0]
//            instead of ending playback.
// Note     : WAIT_SH must be at least 1.
// Revision : 1.0 - initial release
// ============================================================================
module jt49_cmdseq #(
    parameter int AW      = 7,
    parameter int WAIT_SH = 11
) (
    input  wire logic      clk,
    input  wire logic      rst,
    jt49_cmdseq_if.master  bus
);

    localparam int             c_CW        = 8 + WAIT_SH;
    localparam logic [AW-1:0]  c_PC_LAST   = {AW{1'b1}};
    localparam logic [AW-1:0]  c_PC_ONE    = AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_ZERO = '0;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // Registered state and outputs
    logic [2:0]      r_state;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_cmd_addr;
    logic [3:0]      r_psg_addr;
    logic [7:0]      r_psg_din;
    logic            r_psg_wr_n;
    logic            r_busy;
    logic            r_done;
    logic [c_CW-1:0] r_cnt;

    // Next-state values
    logic [2:0]      w_state;
    logic [AW-1:0]   w_pc;
    logic [AW-1:0]   w_cmd_addr;
    logic [3:0]      w_psg_addr;
    logic [7:0]      w_psg_din;
    logic            w_psg_wr_n;
    logic            w_busy;
    logic            w_done;
    logic [c_CW-1:0] w_cnt;
    logic            w_advance;
    logic            w_finish;

    // Command decode helpers
    logic [3:0]      w_op;
    logic [7:0]      w_data;
    logic [c_CW-1:0] w_wait_n;
    logic [AW-1:0]   w_pc_inc;

    assign w_op     = bus.cmd_data[11:8];
    assign w_data   = bus.cmd_data[7:0];
    // Shift is a concatenation so no operand bit is ever lost.
    assign w_wait_n = {w_data, {WAIT_SH{1'b0}}};
    assign w_pc_inc = r_pc + c_PC_ONE;

`ifdef JT49_CMDSEQ_LOOP_EN
    logic [AW-1:0] w_jump;
    assign w_jump = AW'(w_data[6:0]);
`endif

    // Next-state and output decode; abort overrides every other action.
    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_cmd_addr = r_cmd_addr;
        w_psg_addr = r_psg_addr;
        w_psg_din  = r_psg_din;
        w_psg_wr_n = 1'b1;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_cnt      = r_cnt;
        w_advance  = 1'b0;
        w_finish   = 1'b0;

        if (bus.abort && (r_state != c_ST_IDLE)) begin
            w_state = c_ST_IDLE;
            w_busy  = 1'b0;
            w_cnt   = c_CNT_ZERO;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        w_state    = c_ST_FETCH;
                        w_pc       = '0;
                        w_cmd_addr = '0;
                        w_busy     = 1'b1;
                    end
                end
                c_ST_FETCH: begin
                    w_state = c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    if (w_op <= 4'hD) begin
                        w_psg_addr = w_op;
                        w_psg_din  = w_data;
                        w_psg_wr_n = 1'b0;
                        w_advance  = 1'b1;
                    end else if (w_op == 4'hF) begin
                        if (w_wait_n == c_CNT_ZERO) begin
                            w_advance = 1'b1;
                        end else begin
                            w_cnt   = w_wait_n;
                            w_state = c_ST_WAIT;
                        end
                    end else begin
`ifdef JT49_CMDSEQ_LOOP_EN
                        if (w_data[7]) begin
                            w_pc       = w_jump;
                            w_cmd_addr = w_jump;
                            w_state    = c_ST_FETCH;
                        end else begin
                            w_finish = 1'b1;
                        end
`else
                        w_finish = 1'b1;
`endif
                    end
                end
                c_ST_WAIT: begin
                    if (bus.cen) begin
                        w_cnt = r_cnt - c_CNT_ONE;
                        if (r_cnt == c_CNT_ONE) begin
                            w_advance = 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    w_state = c_ST_IDLE;
                end
                default: begin
                    w_state = c_ST_IDLE;
                    w_busy  = 1'b0;
                end
            endcase

            // The last memory slot ends the list instead of wrapping the pc.
            if (w_advance) begin
                if (r_pc == c_PC_LAST) begin
                    w_finish = 1'b1;
                end else begin
                    w_pc       = w_pc_inc;
                    w_cmd_addr = w_pc_inc;
                    w_state    = c_ST_FETCH;
                end
            end

            if (w_finish) begin
                w_state = c_ST_DONE;
                w_busy  = 1'b0;
                w_done  = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= '0;
            r_cmd_addr <= '0;
            r_psg_addr <= 4'h0;
            r_psg_din  <= 8'h00;
            r_psg_wr_n <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= c_CNT_ZERO;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_cmd_addr <= w_cmd_addr;
            r_psg_addr <= w_psg_addr;
            r_psg_din  <= w_psg_din;
            r_psg_wr_n <= w_psg_wr_n;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_cnt      <= w_cnt;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.cmd_addr = r_cmd_addr;
    assign bus.psg_addr = r_psg_addr;
    assign bus.psg_din  = r_psg_din;
    assign bus.psg_wr_n = r_psg_wr_n;

endmodule
`default_nettype wire

// File: tb/tb_jt49_cmdseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt49_cmdseq
// Purpose  : Directed self-checking bench for jt49_cmdseq (AW=4, WAIT_SH=11)
//            with a synchronous command memory model and a cen divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt49_cmdseq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jt49_cmdseq_if #(.AW(4)) bus ();

    jt49_cmdseq #(.AW(4), .WAIT_SH(11)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous command memory: data valid one clock after address.
    logic [11:0] mem [16];
    always @(posedge clk) bus.cmd_data <= mem[bus.cmd_addr];

    // cen is either always high or high on every 4th clock.
    logic [1:0] cen_cnt = 2'd0;
    logic       cen_div = 1'b0;
    always @(posedge clk) cen_cnt <= cen_cnt + 2'd1;
    assign bus.cen = cen_div ? (cen_cnt == 2'd3) : 1'b1;

    // Edge index and cen pulse counter used to time the long wait.
    int   edge_no    = 0;
    int   cen_pulses = 0;
    int   edge_nth   = -100;
    logic cnt_en     = 1'b0;
    always @(posedge clk) begin
        edge_no <= edge_no + 1;
        if (cnt_en && bus.cen) begin
            cen_pulses <= cen_pulses + 1;
            if (cen_pulses == 4095) edge_nth <= edge_no;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        for (int i = 0; i < 16; i++) mem[i] = 12'hE00;
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nw;
        int nd;
        int nb;
        int w_edge;
        bit got;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        fill(12'hE00, 12'hE00, 12'hE00);

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_wr_n", bus.psg_wr_n, 1'b1);
        chk("rst_cmd_addr", bus.cmd_addr, 4'h0);
        chk("rst_psg_addr", bus.psg_addr, 4'h0);
        chk("rst_psg_din", bus.psg_din, 8'h00);

        // Two writes then end-of-list; a start while busy is ignored.
        fill(12'h001, 12'h100, 12'hE00);
        pulse_start();                                   // edge k
        chk("a_busy_k", bus.busy, 1'b1);
        chk("a_wr_n_k", bus.psg_wr_n, 1'b1);
        tick();                                          // k+1
        chk("a_wr_n_k1", bus.psg_wr_n, 1'b1);
        tick();                                          // k+2
        chk("a_wr_n_k2", bus.psg_wr_n, 1'b0);
        chk("a_addr_k2", bus.psg_addr, 4'h0);
        chk("a_din_k2", bus.psg_din, 8'h01);
        tick();                                          // k+3
        chk("a_wr_n_k3", bus.psg_wr_n, 1'b1);
        chk("a_din_hold_k3", bus.psg_din, 8'h01);
        bus.start = 1'b1;
        tick();                                          // k+4
        bus.start = 1'b0;
        chk("a_wr_n_k4", bus.psg_wr_n, 1'b0);
        chk("a_addr_k4", bus.psg_addr, 4'h1);
        chk("a_din_k4", bus.psg_din, 8'h00);
        chk("a_no_restart", bus.cmd_addr, 4'h2);
        tick();                                          // k+5
        chk("a_done_k5", bus.done, 1'b0);
        tick();                                          // k+6
        chk("a_done_k6", bus.done, 1'b1);
        chk("a_busy_k6", bus.busy, 1'b0);
        tick();                                          // k+7
        chk("a_done_k7", bus.done, 1'b0);
        chk("a_busy_k7", bus.busy, 1'b0);

        // Zero-length wait is a no-op.
        fill(12'hF00, 12'h305, 12'hE00);
        pulse_start();
        tick();
        tick();                                          // k+2
        chk("b_wr_n_k2", bus.psg_wr_n, 1'b1);
        chk("b_cmd_addr_k2", bus.cmd_addr, 4'h1);
        tick();
        chk("b_wr_n_k3", bus.psg_wr_n, 1'b1);
        tick();                                          // k+4
        chk("b_wr_n_k4", bus.psg_wr_n, 1'b0);
        chk("b_addr_k4", bus.psg_addr, 4'h3);
        chk("b_din_k4", bus.psg_din, 8'h05);
        tick();
        tick();                                          // k+6
        chk("b_done_k6", bus.done, 1'b1);

        // 4096-tick wait with cen every 4th clock.
        tick();
        fill(12'hF02, 12'h70E, 12'hEFF);
        cen_div = 1'b1;
        pulse_start();                                   // k
        tick();
        tick();                                          // k+2: WAIT entered
        cnt_en = 1'b1;
        got = 1'b0;
        w_edge = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            tick();
            if (!bus.psg_wr_n) begin
                got = 1'b1;
                w_edge = edge_no - 1;
            end
        end
        cnt_en = 1'b0;
        chk("c_write_seen", got, 1'b1);
        chk("c_write_edge", w_edge, edge_nth + 2);
        chk("c_addr", bus.psg_addr, 4'h7);
        chk("c_din", bus.psg_din, 8'h0E);
        tick();
        tick();
        chk("c_done", bus.done, 1'b1);
        cen_div = 1'b0;
        tick();

        // Abort on the DECODE cycle of a write.
        fill(12'h001, 12'h100, 12'hE00);
        pulse_start();                                   // k
        tick();                                          // k+1: DECODE
        bus.abort = 1'b1;
        tick();                                          // k+2
        bus.abort = 1'b0;
        chk("d_wr_n", bus.psg_wr_n, 1'b1);
        chk("d_busy", bus.busy, 1'b0);
        chk("d_done", bus.done, 1'b0);
        chk("d_addr_hold", bus.psg_addr, 4'h7);
        chk("d_din_hold", bus.psg_din, 8'h0E);
        tick();
        tick();
        chk("d_idle_wr_n", bus.psg_wr_n, 1'b1);
        chk("d_idle_busy", bus.busy, 1'b0);
        pulse_start();                                   // k'
        chk("d_re_busy", bus.busy, 1'b1);
        chk("d_re_cmd_addr", bus.cmd_addr, 4'h0);
        tick();
        tick();                                          // k'+2
        chk("d_re_wr_n", bus.psg_wr_n, 1'b0);
        chk("d_re_addr", bus.psg_addr, 4'h0);
        chk("d_re_din", bus.psg_din, 8'h01);
        tick();
        tick();
        tick();
        tick();                                          // k'+6
        chk("d_re_done", bus.done, 1'b1);
        tick();

        // Abort during a 2048-tick wait; the counter must not survive.
        fill(12'hF01, 12'h70E, 12'hE00);
        pulse_start();
        for (int i = 0; i < 100; i++) tick();
        chk("e_busy_pre", bus.busy, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("e_busy", bus.busy, 1'b0);
        chk("e_done", bus.done, 1'b0);
        chk("e_wr_n", bus.psg_wr_n, 1'b1);
        nw = 0;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (!bus.psg_wr_n) nw++;
            if (bus.done) nd++;
            if (bus.busy) nb++;
        end
        chk("e_no_writes", nw, 0);
        chk("e_no_done", nd, 0);
        chk("e_stay_idle", nb, 0);
        pulse_start();
        chk("e_re_cmd_addr", bus.cmd_addr, 4'h0);
        chk("e_re_busy", bus.busy, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // Memory full of writes: 16 writes then done, no wrap.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            logic [7:0] dv;
            op = 4'(i % 14);
            dv = 8'(i * 17);
            mem[i] = {op, dv};
        end
        pulse_start();
        nw = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (!bus.psg_wr_n) begin
                if (nw < 16) begin
                    chk($sformatf("f_addr%0d", nw), bus.psg_addr, mem[nw][11:8]);
                    chk($sformatf("f_din%0d", nw), bus.psg_din, mem[nw][7:0]);
                end
                nw++;
            end
            if (bus.done) got = 1'b1;
        end
        chk("f_done_seen", got, 1'b1);
        chk("f_write_count", nw, 16);
        tick();
        chk("f_busy_after", bus.busy, 1'b0);
        chk("f_wr_n_after", bus.psg_wr_n, 1'b1);

        // Op E with data[7]=1: jump when the loop option is built, else end.
        fill(12'h8F0, 12'hE80, 12'hE00);
        pulse_start();                                   // k
        tick();
        tick();                                          // k+2
        chk("g_wr_n_k2", bus.psg_wr_n, 1'b0);
        chk("g_addr_k2", bus.psg_addr, 4'h8);
        chk("g_din_k2", bus.psg_din, 8'hF0);
`ifdef JT49_CMDSEQ_LOOP_EN
        nd = 0;
        for (int i = 3; i <= 40; i++) begin
            tick();
            chk($sformatf("g_loop_wr_n_k%0d", i), bus.psg_wr_n, ((i - 2) % 4 == 0) ? 1'b0 : 1'b1);
            if (bus.done) nd++;
        end
        chk("g_loop_no_done", nd, 0);
        chk("g_loop_busy", bus.busy, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("g_loop_abort_busy", bus.busy, 1'b0);
        chk("g_loop_abort_done", bus.done, 1'b0);
`else
        tick();                                          // k+3
        chk("g_wr_n_k3", bus.psg_wr_n, 1'b1);
        tick();                                          // k+4
        chk("g_done_k4", bus.done, 1'b1);
        chk("g_busy_k4", bus.busy, 1'b0);
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.psg_wr_n) nw++;
        end
        chk("g_no_more_writes", nw, 0);
`endif
        tick();

        // Reset while a write strobe is low.
        fill(12'h555, 12'hE00, 12'hE00);
        pulse_start();
        tick();
        tick();                                          // k+2: wr_n low
        chk("h_wr_n_pre", bus.psg_wr_n, 1'b0);
        chk("h_addr_pre", bus.psg_addr, 4'h5);
        rst = 1'b1;
        tick();
        chk("h_wr_n", bus.psg_wr_n, 1'b1);
        chk("h_addr", bus.psg_addr, 4'h0);
        chk("h_din", bus.psg_din, 8'h00);
        chk("h_busy", bus.busy, 1'b0);
        chk("h_done", bus.done, 1'b0);
        chk("h_cmd_addr", bus.cmd_addr, 4'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("h_stay_idle", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
